// File: rtl/ahb_divider_slave.sv
// AHB-Lite slave wrapping a 32-bit radix-2 restoring divider with wait states on result reads.
// Optional define DIV_IRQ_EN adds the DIV_IRQ completion interrupt and STATUS bit3.
//
// state  | meaning
// S_IDLE | waiting for START; results and flags hold
// S_RUN  | one shift-subtract step per cycle on operand magnitudes
// S_FIX  | apply signs / divide-by-zero result, write outputs
module ahb_divider_slave #(
    parameter int ADDR_W = 8,
    parameter int ITER   = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
`ifdef DIV_IRQ_EN
    output logic              DIV_IRQ,
`endif
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic [1:0]        HRESP
);
    localparam int AW = ADDR_W - 2;
    localparam int CW = $clog2(ITER);
    localparam logic [AW-1:0] A_DIVIDEND = AW'(0);
    localparam logic [AW-1:0] A_DIVISOR  = AW'(1);
    localparam logic [AW-1:0] A_CTRL     = AW'(2);
    localparam logic [AW-1:0] A_STATUS   = AW'(3);
    localparam logic [AW-1:0] A_QUOT     = AW'(4);
    localparam logic [AW-1:0] A_REM      = AW'(5);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
    state_t state, state_nxt;

    logic          dp_valid, dp_write;
    logic [AW-1:0] dp_addr;
    logic [31:0]   dividend_r, divisor_r, quo_r, rem_r, dvs_r, q_out, r_out;
    logic [CW-1:0] cnt_r;
    logic          neg_q_r, neg_r_r, busy_r, done_r, dz_r, irq_bit;
    logic          wr_commit, start_acc, stall;
    logic [31:0]   abs_dd, abs_dv, fix_q, fix_r;
    logic [32:0]   r_shift, r_diff;

    logic unused_ok;
    assign unused_ok = ^{HSIZE, HBURST, HADDR[1:0], HTRANS[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else if (HREADY) begin
            dp_valid <= HSEL & HTRANS[1];
            dp_write <= HWRITE;
            dp_addr  <= HADDR[ADDR_W-1:2];
        end
    end

    assign wr_commit = dp_valid & dp_write & HREADYOUT;
    assign start_acc = wr_commit & (dp_addr == A_CTRL) & HWDATA[0] & (state == S_IDLE);

    assign abs_dd  = (HWDATA[1] & dividend_r[31]) ? (~dividend_r + 32'd1) : dividend_r;
    assign abs_dv  = (HWDATA[1] & divisor_r[31])  ? (~divisor_r + 32'd1)  : divisor_r;
    assign r_shift = {rem_r, quo_r[31]};
    assign r_diff  = r_shift - {1'b0, dvs_r};

    // On divide-by-zero quo_r carries the raw dividend straight through to REMAINDER.
    assign fix_q = (dvs_r == 32'd0) ? 32'hFFFF_FFFF : (neg_q_r ? (~quo_r + 32'd1) : quo_r);
    assign fix_r = (dvs_r == 32'd0) ? quo_r : (neg_r_r ? (~rem_r + 32'd1) : rem_r);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_acc) state_nxt = (divisor_r == 32'd0) ? S_FIX : S_RUN;
            S_RUN:  if (cnt_r == CW'(ITER - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dividend_r <= '0; divisor_r <= '0; quo_r <= '0; rem_r <= '0; dvs_r <= '0;
            q_out <= '0; r_out <= '0; cnt_r <= '0;
            neg_q_r <= 1'b0; neg_r_r <= 1'b0; busy_r <= 1'b0; done_r <= 1'b0; dz_r <= 1'b0;
        end else begin
            if (wr_commit && dp_addr == A_DIVIDEND) dividend_r <= HWDATA;
            if (wr_commit && dp_addr == A_DIVISOR)  divisor_r  <= HWDATA;
            case (state)
                S_IDLE: if (start_acc) begin
                    busy_r  <= 1'b1;
                    done_r  <= 1'b0;
                    dz_r    <= 1'b0;
                    cnt_r   <= '0;
                    rem_r   <= '0;
                    dvs_r   <= abs_dv;
                    quo_r   <= (divisor_r == 32'd0) ? dividend_r : abs_dd;
                    neg_q_r <= HWDATA[1] & (dividend_r[31] ^ divisor_r[31]);
                    neg_r_r <= HWDATA[1] & dividend_r[31];
                end
                S_RUN: begin
                    quo_r <= {quo_r[30:0], ~r_diff[32]};
                    rem_r <= r_diff[32] ? r_shift[31:0] : r_diff[31:0];
                    cnt_r <= cnt_r + 1'b1;
                end
                S_FIX: begin
                    q_out  <= fix_q;
                    r_out  <= fix_r;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    dz_r   <= (dvs_r == 32'd0);
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_IRQ_EN
    logic irq_r;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            irq_r <= 1'b0;
        else if (state == S_FIX)
            irq_r <= 1'b1;
        else if (start_acc || (wr_commit && dp_addr == A_STATUS && HWDATA[1]))
            irq_r <= 1'b0;
    end
    assign DIV_IRQ = irq_r;
    assign irq_bit = irq_r;
`else
    assign irq_bit = 1'b0;
`endif

    // In S_FIX the final result is already valid, so a pending result read completes there.
    assign stall     = dp_valid & ~dp_write & ((dp_addr == A_QUOT) | (dp_addr == A_REM)) &
                       (state == S_RUN);
    assign HREADYOUT = ~stall;
    assign HRESP     = 2'b00;

    always_comb begin
        HRDATA = 32'd0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                A_DIVIDEND: HRDATA = dividend_r;
                A_DIVISOR:  HRDATA = divisor_r;
                A_STATUS:   HRDATA = {28'd0, irq_bit, dz_r, done_r, busy_r};
                A_QUOT:     HRDATA = (state == S_FIX) ? fix_q : q_out;
                A_REM:      HRDATA = (state == S_FIX) ? fix_r : r_out;
                default:    HRDATA = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_divider_slave.sv
// Directed bench for ahb_divider_slave: vector table of divisions plus bus-timing sequences.
module tb_ahb_divider_slave;
    logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, HREADY;
    logic [7:0]  HADDR = '0;
    logic [1:0]  HTRANS = 2'b00, HRESP;
    logic [2:0]  HSIZE = 3'b010, HBURST = 3'b000;
    logic [31:0] HWDATA = '0, HRDATA;
    logic        HREADYOUT;
`ifdef DIV_IRQ_EN
    logic        DIV_IRQ;
    localparam logic [31:0] IRQ_ST = 32'h8;
`else
    localparam logic [31:0] IRQ_ST = 32'h0;
`endif

    int total = 0, bad = 0;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_divider_slave dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
`ifdef DIV_IRQ_EN
        .DIV_IRQ(DIV_IRQ),
`endif
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    typedef struct {
        logic [31:0] dd, dv, ctrl, q, r, st;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output int waits);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        waits = 0;
        while (!HREADYOUT && waits < 100) begin
            waits++;
            @(negedge HCLK);
        end
        if (waits >= 100) check("read_timeout", 32'(waits), 32'd0);
        d = HRDATA;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        int w;
        bus_read(a, d, w);
    endtask

    task automatic wait_done();
        logic [31:0] s;
        int n = 0;
        do begin
            rd(8'h0C, s);
            n++;
        end while ((s[1] !== 1'b1 || s[0] !== 1'b0) && n < 60);
        if (n >= 60) check("done_timeout", s, 32'h2);
    endtask

    // CTRL write followed by back-to-back STATUS reads, one per cycle; counts BUSY samples.
    task automatic busy_seq(input logic [31:0] ctrl, output int nbusy, output logic [31:0] last);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 8'h08; HWRITE = 1'b1;
        @(negedge HCLK);
        HWDATA = ctrl; HADDR = 8'h0C; HWRITE = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge HCLK);
            last = HRDATA;
            if (last[0]) nbusy++;
        end
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
    endtask

    vec_t vecs[12];
    logic [31:0] d, qv, rv;
    int w, nb;

    initial begin
        vecs[0]  = '{32'd100,       32'd7,         32'h1, 32'd14,        32'd2,         32'h2};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'h3, 32'hFFFFFFF2,  32'hFFFFFFFE,  32'h2};
        vecs[2]  = '{32'h80000000,  32'hFFFFFFFF,  32'h3, 32'h80000000,  32'h0,         32'h2};
        vecs[3]  = '{32'h1234,      32'h0,         32'h1, 32'hFFFFFFFF,  32'h1234,      32'h6};
        vecs[4]  = '{32'hFFFFFFFF,  32'd1,         32'h1, 32'hFFFFFFFF,  32'h0,         32'h2};
        vecs[5]  = '{32'hFFFFFFFF,  32'h10,        32'h1, 32'h0FFFFFFF,  32'hF,         32'h2};
        vecs[6]  = '{32'd100,       32'hFFFFFFF9,  32'h3, 32'hFFFFFFF2,  32'd2,         32'h2};
        vecs[7]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'h3, 32'd14,        32'hFFFFFFFE,  32'h2};
        vecs[8]  = '{32'd7,         32'd100,       32'h1, 32'd0,         32'd7,         32'h2};
        vecs[9]  = '{32'h80000000,  32'hFFFFFFFF,  32'h1, 32'd0,         32'h80000000,  32'h2};
        vecs[10] = '{32'hFFFFFFFB,  32'h0,         32'h3, 32'hFFFFFFFF,  32'hFFFFFFFB,  32'h6};
        vecs[11] = '{32'hDEADBEEF,  32'h1000,      32'h1, 32'h000DEADB,  32'h00000EEF,  32'h2};

        // reset state
        repeat (3) @(negedge HCLK);
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_hresp", 32'(HRESP), 32'd0);
        HRESETn = 1'b1;
        rd(8'h0C, d); check("rst_status", d, 32'h0);
        rd(8'h10, d); check("rst_quot", d, 32'h0);
        rd(8'h14, d); check("rst_rem", d, 32'h0);

        // 100/7 with the quotient read issued right after START; REMAINDER read pipelined behind it
        bus_write(8'h00, 32'd100);
        bus_write(8'h04, 32'd7);
        bus_write(8'h08, 32'h1);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 8'h10; HWRITE = 1'b0;
        @(negedge HCLK);
        HADDR = 8'h14;
        w = 0;
        while (!HREADYOUT && w < 100) begin
            w++;
            @(negedge HCLK);
        end
        qv = HRDATA;
        check("stall_in_range", 32'((w >= 30 && w <= 32) ? 1 : 0), 32'd1);
        check("stall_quot", qv, 32'd14);
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        check("rem_zero_wait", 32'(HREADYOUT), 32'd1);
        check("pipelined_rem", HRDATA, 32'd2);
        bus_read(8'h14, d, w);
        check("rem_waits", 32'(w), 32'd0);
        check("rem_again", d, 32'd2);
        rd(8'h0C, d); check("status_done", d, 32'h2 | IRQ_ST);

        // BUSY width for a normal division and for divide-by-zero
        busy_seq(32'h1, nb, d);
        check("busy_cycles", 32'(nb), 32'd33);
        check("busy_end_status", d, 32'h2 | IRQ_ST);
        bus_write(8'h04, 32'd0);
        busy_seq(32'h1, nb, d);
        check("dz_busy_cycles", 32'(nb), 32'd1);
        check("dz_end_status", d, 32'h6 | IRQ_ST);

        // vector table
        foreach (vecs[i]) begin
            bus_write(8'h00, vecs[i].dd);
            bus_write(8'h04, vecs[i].dv);
            bus_write(8'h08, vecs[i].ctrl);
            wait_done();
            rd(8'h10, qv); check($sformatf("vec%0d_quot", i), qv, vecs[i].q);
            rd(8'h14, rv); check($sformatf("vec%0d_rem", i), rv, vecs[i].r);
            rd(8'h0C, d);  check($sformatf("vec%0d_status", i), d, vecs[i].st | IRQ_ST);
        end

        // register map odds and ends
        rd(8'h08, d); check("ctrl_reads_zero", d, 32'h0);
        rd(8'h18, d); check("unmapped_read", d, 32'h0);
        bus_write(8'h08, 32'h0);
        rd(8'h0C, d); check("start0_no_effect", d, 32'h2 | IRQ_ST);
        bus_write(8'h1C, 32'h5A5A5A5A);
        rd(8'h00, d); check("unmapped_write", d, 32'hDEADBEEF);

        // collisions while BUSY
        bus_write(8'h00, 32'd50);
        bus_write(8'h04, 32'd5);
        bus_write(8'h08, 32'h1);
        bus_write(8'h04, 32'd3);
        bus_write(8'h08, 32'h1);
        rd(8'h10, qv); check("busy_start_quot", qv, 32'd10);
        rd(8'h14, rv); check("busy_start_rem", rv, 32'd0);
        rd(8'h04, d);  check("busy_divisor_write", d, 32'd3);
        bus_write(8'h08, 32'h1);
        wait_done();
        rd(8'h10, qv); check("restart_quot", qv, 32'd16);
        rd(8'h14, rv); check("restart_rem", rv, 32'd2);

`ifdef DIV_IRQ_EN
        check("irq_high", 32'(DIV_IRQ), 32'd1);
        bus_write(8'h0C, 32'h1);
        @(negedge HCLK);
        check("irq_bit1_only", 32'(DIV_IRQ), 32'd1);
        bus_write(8'h0C, 32'h2);
        @(negedge HCLK);
        check("irq_cleared", 32'(DIV_IRQ), 32'd0);
        rd(8'h0C, d); check("irq_status_clear", d, 32'h2);
`else
        bus_write(8'h0C, 32'hF);
        rd(8'h0C, d); check("status_write_ignored", d, 32'h2);
`endif

        // reset in the middle of a division
        bus_write(8'h00, 32'd1000);
        bus_write(8'h04, 32'd3);
        bus_write(8'h08, 32'h1);
        repeat (10) @(negedge HCLK);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
        HRESETn = 1'b1;
        rd(8'h0C, d); check("midrst_status", d, 32'h0);
        rd(8'h10, d); check("midrst_quot", d, 32'h0);
        rd(8'h14, d); check("midrst_rem", d, 32'h0);
        rd(8'h00, d); check("midrst_dividend", d, 32'h0);
`ifdef DIV_IRQ_EN
        check("midrst_irq", 32'(DIV_IRQ), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
